// File: rtl/aes_ctr_seq_pkg.sv
// Shared sizing, sparse state encoding and slice helpers for the CTR counter sequencer.
// Used by aes_ctr_seq, aes_ctr_seq_if and aes_ctr_seq_bank.
package aes_ctr_seq_pkg;

    localparam int SliceSizeCtr  = 16;
    localparam int NumSlicesCtr  = 8;
    localparam int SliceIdxWidth = $clog2(NumSlicesCtr);
    localparam int NumIncrW      = 4;
    localparam int CtrWidth      = SliceSizeCtr * NumSlicesCtr;

    // Every pair of codes differs in at least three bits, so a single upset
    // never lands on another legal state.
    typedef enum logic [5:0] {
        CTR_IDLE   = 6'b011101,
        CTR_LAUNCH = 6'b110011,
        CTR_WAIT   = 6'b101010,
        CTR_DONE   = 6'b000110,
        CTR_ERROR  = 6'b100101
    } aes_ctr_seq_e;

    function automatic logic [NumSlicesCtr-1:0] slice_onehot(input logic [SliceIdxWidth-1:0] idx);
        return NumSlicesCtr'(1) << idx;
    endfunction

    // In inc32 mode only the two low slices (bits [31:0]) may be rewritten.
    function automatic logic [NumSlicesCtr-1:0] slice_we_mask(input logic inc32);
        logic [NumSlicesCtr-1:0] mask;
        mask = '1;
        if (inc32) begin
            mask[NumSlicesCtr-1:2] = '0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/aes_ctr_seq_if.sv
// Requester and slice-FSM signals of the CTR counter sequencer.
// mode_inc32_i exists only when AES_CTR_SEQ_INC32_EN is defined.
interface aes_ctr_seq_if;
    import aes_ctr_seq_pkg::*;

    logic                     iv_load_i;
    logic [CtrWidth-1:0]      iv_i;
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [NumIncrW-1:0]      req_num_i;
`ifdef AES_CTR_SEQ_INC32_EN
    logic                     mode_inc32_i;
`endif
    logic                     done_o;
    logic [CtrWidth-1:0]      ctr_o;

    logic                     fsm_incr_o;
    logic                     fsm_ready_i;
    logic [SliceIdxWidth-1:0] fsm_slice_idx_i;
    logic [SliceSizeCtr-1:0]  fsm_slice_o;
    logic [SliceSizeCtr-1:0]  fsm_slice_i;
    logic                     fsm_we_i;
    logic                     fsm_alert_i;

    modport slave (
        input  iv_load_i, iv_i, req_valid_i, req_num_i,
`ifdef AES_CTR_SEQ_INC32_EN
        input  mode_inc32_i,
`endif
        input  fsm_ready_i, fsm_slice_idx_i, fsm_slice_i, fsm_we_i, fsm_alert_i,
        output req_ready_o, done_o, ctr_o, fsm_incr_o, fsm_slice_o
    );

    modport master (
        output iv_load_i, iv_i, req_valid_i, req_num_i,
`ifdef AES_CTR_SEQ_INC32_EN
        output mode_inc32_i,
`endif
        output fsm_ready_i, fsm_slice_idx_i, fsm_slice_i, fsm_we_i, fsm_alert_i,
        input  req_ready_o, done_o, ctr_o, fsm_incr_o, fsm_slice_o
    );

endinterface

// File: rtl/aes_ctr_seq_bank.sv
// 128-bit counter register held as independent slices: full-width load,
// per-slice write enable and a slice read mux for the incrementer.
module aes_ctr_seq_bank
    import aes_ctr_seq_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_load,
    input  logic [CtrWidth-1:0]      i_load_val,
    input  logic [NumSlicesCtr-1:0]  i_we,
    input  logic [SliceSizeCtr-1:0]  i_wdata,
    input  logic [SliceIdxWidth-1:0] i_rd_idx,
    output logic [SliceSizeCtr-1:0]  o_rd_slice,
    output logic [CtrWidth-1:0]      o_ctr
);

    logic [CtrWidth-1:0] w_ctr;

    for (genvar gi = 0; gi < NumSlicesCtr; gi++) begin : g_slice
        logic [SliceSizeCtr-1:0] r_slice;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_slice <= '0;
            end else if (i_load) begin
                r_slice <= i_load_val[gi*SliceSizeCtr +: SliceSizeCtr];
            end else if (i_we[gi]) begin
                r_slice <= i_wdata;
            end
        end

        assign w_ctr[gi*SliceSizeCtr +: SliceSizeCtr] = r_slice;
    end

    assign o_rd_slice = w_ctr[i_rd_idx*SliceSizeCtr +: SliceSizeCtr];
    assign o_ctr      = w_ctr;

endmodule

// File: rtl/aes_ctr_seq.sv
// CTR-mode counter sequencer: runs the slice-serial incrementer N times per request.
// Optional AES_CTR_SEQ_INC32_EN adds mode_inc32_i (GCM inc32: only bits [31:0] change).
module aes_ctr_seq
    import aes_ctr_seq_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    aes_ctr_seq_if.slave ctr_if,
    output logic         alert_o
);

    aes_ctr_seq_e            r_state;
    logic [NumIncrW-1:0]     r_remaining;
    logic                    r_done;
    logic                    r_alert;

    logic                    w_inc32;
    logic                    w_state_valid;
    logic                    w_err;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_incr;
    logic                    w_wait_we;
    logic                    w_last_slice;
    logic                    w_load;
    logic [NumSlicesCtr-1:0] w_slice_we;

`ifdef AES_CTR_SEQ_INC32_EN
    logic                    r_inc32;
    assign w_inc32 = r_inc32;
`else
    assign w_inc32 = 1'b0;
`endif

    assign w_state_valid = r_state inside {CTR_IDLE, CTR_LAUNCH, CTR_WAIT, CTR_DONE, CTR_ERROR};

    // Any of these forces ERROR on the next edge; the same cycle is already
    // treated as faulty so no write, load or handshake slips through.
    assign w_err = ctr_if.fsm_alert_i
                || (ctr_if.fsm_we_i && (r_state != CTR_WAIT))
                || !w_state_valid;

    assign w_ready  = !rst_i && (r_state == CTR_IDLE) && ctr_if.fsm_ready_i
                   && !ctr_if.iv_load_i && !w_err;
    assign w_accept = ctr_if.req_valid_i && w_ready;
    assign w_incr   = (r_state == CTR_LAUNCH) && ctr_if.fsm_ready_i && !w_err;
    assign w_load   = (r_state == CTR_IDLE) && ctr_if.iv_load_i && !w_err;

    assign w_wait_we    = ctr_if.fsm_we_i && (r_state == CTR_WAIT) && !w_err;
    assign w_last_slice = ctr_if.fsm_slice_idx_i == SliceIdxWidth'(NumSlicesCtr - 1);
    assign w_slice_we   = slice_onehot(ctr_if.fsm_slice_idx_i)
                        & slice_we_mask(w_inc32)
                        & {NumSlicesCtr{w_wait_we}};

    aes_ctr_seq_bank u_bank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_load),
        .i_load_val (ctr_if.iv_i),
        .i_we       (w_slice_we),
        .i_wdata    (ctr_if.fsm_slice_i),
        .i_rd_idx   (ctr_if.fsm_slice_idx_i),
        .o_rd_slice (ctr_if.fsm_slice_o),
        .o_ctr      (ctr_if.ctr_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= CTR_IDLE;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_alert     <= 1'b0;
`ifdef AES_CTR_SEQ_INC32_EN
            r_inc32     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_err) begin
                r_state <= CTR_ERROR;
                r_alert <= 1'b1;
            end else begin
                case (r_state)
                    CTR_IDLE: begin
                        if (w_accept) begin
                            r_remaining <= ctr_if.req_num_i;
`ifdef AES_CTR_SEQ_INC32_EN
                            r_inc32     <= ctr_if.mode_inc32_i;
`endif
                            if (ctr_if.req_num_i == '0) begin
                                r_state <= CTR_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= CTR_LAUNCH;
                            end
                        end
                    end
                    CTR_LAUNCH: begin
                        if (w_incr) begin
                            r_state <= CTR_WAIT;
                        end
                    end
                    CTR_WAIT: begin
                        // One increment ends with the write of the top slice.
                        if (w_wait_we && w_last_slice) begin
                            r_remaining <= r_remaining - NumIncrW'(1);
                            if (r_remaining == NumIncrW'(1)) begin
                                r_state <= CTR_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= CTR_LAUNCH;
                            end
                        end
                    end
                    CTR_DONE: begin
                        r_state <= CTR_IDLE;
                    end
                    CTR_ERROR: begin
                        r_state <= CTR_ERROR;
                        r_alert <= 1'b1;
                    end
                    default: begin
                        r_state <= CTR_ERROR;
                        r_alert <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ctr_if.req_ready_o = w_ready;
    assign ctr_if.fsm_incr_o  = w_incr;
    assign ctr_if.done_o      = r_done;
    assign alert_o            = r_alert;

endmodule

// File: tb/tb_aes_ctr_seq.sv
// Scoreboard bench for aes_ctr_seq with a behavioural slice-serial incrementer
// and a 128-bit arithmetic reference; honours AES_CTR_SEQ_INC32_EN when defined.
module tb_aes_ctr_seq;
    import aes_ctr_seq_pkg::*;

    typedef struct {
        logic [127:0] ctr;
        int unsigned  cyc;
        int           n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alert;
    logic        inj_we;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        exp_q[$];
    logic [127:0] m_ctr;

    aes_ctr_seq_if bus();

    aes_ctr_seq dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctr_if  (bus),
        .alert_o (alert)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef AES_CTR_SEQ_INC32_EN
    logic tb_mode = 1'b0;
    assign bus.mode_inc32_i = tb_mode;
`endif

    // Behavioural slice-serial incrementer: one slice per cycle, LSB slice first.
    logic                     m_busy;
    logic [SliceIdxWidth-1:0] m_idx;
    logic                     m_carry;
    logic [SliceSizeCtr:0]    m_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_idx   <= '0;
            m_carry <= 1'b0;
        end else if (!m_busy) begin
            if (bus.fsm_incr_o) begin
                m_busy  <= 1'b1;
                m_idx   <= '0;
                m_carry <= 1'b1;
            end
        end else begin
            m_carry <= m_sum[SliceSizeCtr];
            m_idx   <= m_idx + 1'b1;
            if (m_idx == SliceIdxWidth'(NumSlicesCtr - 1)) m_busy <= 1'b0;
        end
    end

    assign m_sum               = {1'b0, bus.fsm_slice_o} + (SliceSizeCtr + 1)'(m_carry);
    assign bus.fsm_slice_i     = m_sum[SliceSizeCtr-1:0];
    assign bus.fsm_we_i        = m_busy | inj_we;
    assign bus.fsm_ready_i     = !m_busy;
    assign bus.fsm_slice_idx_i = m_idx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ref_incr(input logic [127:0] c, input int n, input bit inc32);
        logic [31:0] lo;
        if (inc32) begin
            lo = c[31:0] + 32'(n);
            return {c[127:32], lo};
        end
        return c + 128'(n);
    endfunction

    // Monitor: counts FSM activity and retires one scoreboard entry per done pulse.
    int we_cnt   = 0;
    int incr_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            we_cnt   = 0;
            incr_cnt = 0;
        end else begin
            if (bus.fsm_we_i)   we_cnt++;
            if (bus.fsm_incr_o) incr_cnt++;
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 128'(bus.done_o), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("txn n=%0d ctr=%h done at cycle %0d", e.n, bus.ctr_o, cyc);
                    check("ctr_value", bus.ctr_o, e.ctr);
                    check("done_cycle", 128'(cyc), 128'(e.cyc));
                    check("we_pulses", 128'(we_cnt), 128'(8 * e.n));
                    check("incr_pulses", 128'(incr_cnt), 128'(e.n));
                    check("alert_quiet", 128'(alert), 128'(0));
                end
                we_cnt   = 0;
                incr_cnt = 0;
            end
        end
    end

    task automatic load_iv(input logic [127:0] v);
        @(posedge clk); #1;
        bus.iv_load_i = 1'b1;
        bus.iv_i      = v;
        @(posedge clk); #1;
        bus.iv_load_i = 1'b0;
        m_ctr = v;
    endtask

    task automatic do_req(input int n, input bit inc32);
        bit got = 0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_num_i   = NumIncrW'(n);
`ifdef AES_CTR_SEQ_INC32_EN
        tb_mode = inc32;
`endif
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                got = 1;
                break;
            end
        end
        check("req_accepted", 128'(got), 128'(1));
        if (got) begin
            m_ctr = ref_incr(m_ctr, n, inc32);
            exp_q.push_back('{m_ctr, cyc + ((n == 0) ? 1 : 9 * n + 1), n});
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("done_seen", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_alert", 128'(alert), 128'(0));
        check("rst_ctr", bus.ctr_o, 128'(0));
        check("rst_done", 128'(bus.done_o), 128'(0));
        check("rst_incr", 128'(bus.fsm_incr_o), 128'(0));
        check("rst_ready", 128'(bus.req_ready_o), 128'(0));
        @(posedge clk); #1;
        rst   = 1'b0;
        m_ctr = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        logic [127:0] snap;
        bit           got;
        bit           inc;
        int           n;

        bus.iv_load_i   = 1'b0;
        bus.iv_i        = '0;
        bus.req_valid_i = 1'b0;
        bus.req_num_i   = '0;
        bus.fsm_alert_i = 1'b0;
        inj_we          = 1'b0;
        m_ctr           = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(bus.req_ready_o), 128'(0));
        check("reset_done", 128'(bus.done_o), 128'(0));
        check("reset_incr", 128'(bus.fsm_incr_o), 128'(0));
        check("reset_alert", 128'(alert), 128'(0));
        check("reset_ctr", bus.ctr_o, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        load_iv(128'h0);
        do_req(1, 1'b0);
        wait_done();

        load_iv(128'h0000_FFFF);
        do_req(3, 1'b0);
        wait_done();

        load_iv('1);
        do_req(1, 1'b0);
        wait_done();

        // Load and request in the same IDLE cycle: load wins, request follows.
        v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(posedge clk); #1;
        bus.iv_load_i   = 1'b1;
        bus.iv_i        = v;
        bus.req_valid_i = 1'b1;
        bus.req_num_i   = '0;
`ifdef AES_CTR_SEQ_INC32_EN
        tb_mode = 1'b0;
`endif
        @(negedge clk);
        check("ready_blocked_by_load", 128'(bus.req_ready_o), 128'(0));
        @(posedge clk); #1;
        bus.iv_load_i = 1'b0;
        m_ctr = v;
        @(negedge clk);
        check("ready_after_load", 128'(bus.req_ready_o), 128'(1));
        if (bus.req_ready_o) exp_q.push_back('{v, cyc + 1, 0});
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        wait_done();

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 2) == 0) v[47:0] = '1;
                if ($urandom_range(0, 5) == 0) v = '1;
                load_iv(v);
            end
            n   = $urandom_range(0, 15);
            inc = 1'b0;
`ifdef AES_CTR_SEQ_INC32_EN
            inc = 1'($urandom_range(0, 1));
`endif
            do_req(n, inc);
            wait_done();
        end

`ifdef AES_CTR_SEQ_INC32_EN
        load_iv(128'hA_FFFF_FFFF);
        do_req(1, 1'b1);
        wait_done();
        check("inc32_result", bus.ctr_o, 128'hA_0000_0000);
`endif

        // FSM alert in the middle of an increment: carry-heavy IV so any
        // leaked writeback after the alert would change the counter.
        v = {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
        load_iv(v);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_num_i   = NumIncrW'(2);
`ifdef AES_CTR_SEQ_INC32_EN
        tb_mode = 1'b0;
`endif
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                got = 1;
                break;
            end
        end
        check("err_req_accepted", 128'(got), 128'(1));
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.fsm_alert_i = 1'b1;
        @(posedge clk); #1;
        bus.fsm_alert_i = 1'b0;
        @(negedge clk);
        snap = bus.ctr_o;
        check("alert_set", 128'(alert), 128'(1));
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_num_i   = NumIncrW'(1);
        @(negedge clk);
        check("err_ready_low", 128'(bus.req_ready_o), 128'(0));
        check("err_incr_low", 128'(bus.fsm_incr_o), 128'(0));
        repeat (15) @(negedge clk);
        check("err_ctr_frozen", bus.ctr_o, snap);
        check("err_alert_sticky", 128'(alert), 128'(1));
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        pulse_reset();

        // Stray writeback strobe while idle.
        v = {$urandom, $urandom, $urandom, $urandom};
        load_iv(v);
        @(posedge clk); #1;
        inj_we = 1'b1;
        @(posedge clk); #1;
        inj_we          = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_num_i   = NumIncrW'(1);
        @(negedge clk);
        check("idle_we_alert", 128'(alert), 128'(1));
        check("idle_we_ready_low", 128'(bus.req_ready_o), 128'(0));
        check("idle_we_ctr_kept", bus.ctr_o, v);
        repeat (5) @(negedge clk);
        check("idle_we_ctr_frozen", bus.ctr_o, v);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        pulse_reset();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
